// File: rtl/clk_div_pkg.sv
// Shared constants and helpers for the clock divider bank.
package clk_div_pkg;

    localparam logic MODE_SQUARE = 1'b0;
    localparam logic MODE_TICK   = 1'b1;

    // Channel-select width; a single channel still gets a 1-bit select.
    function automatic int ch_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/clk_div_channel.sv
// One divider channel: counter, active/pending config and registered outputs.
module clk_div_channel
    import clk_div_pkg::*;
#(
    parameter int DIV_W       = 8,
    parameter int DEFAULT_DIV = 50
) (
    input  logic             clock,
    input  logic             rst_n,
    input  logic             en,
    input  logic             sync,
    input  logic             wr,
    input  logic [DIV_W-1:0] wdiv,
    input  logic             wmode,
    output logic             clk_out,
    output logic             tick,
    output logic             busy
);

    logic [DIV_W-1:0] cnt_q, cnt_d, div_q, div_d, pdiv_q, pdiv_d;
    logic             mode_q, mode_d, pmode_q, pmode_d, pend_q, pend_d;
    logic             clk_q, clk_d, tick_q, tick_d;
    logic             tc, chg, nmode;

    // Next-state: disable > sync > terminal count > count; config capture last.
    always_comb begin
        cnt_d   = cnt_q;
        div_d   = div_q;
        mode_d  = mode_q;
        pdiv_d  = pdiv_q;
        pmode_d = pmode_q;
        pend_d  = pend_q;
        clk_d   = clk_q;
        tick_d  = 1'b0;
        tc      = (cnt_q == div_q);
        nmode   = pend_q ? pmode_q : mode_q;
        chg     = pend_q && (pmode_q != mode_q);
        if (!en || sync || tc) begin
            cnt_d = '0;
            // Pending config only ever lands while cnt restarts, so no runt periods.
            if (pend_q) begin
                div_d  = pdiv_q;
                mode_d = pmode_q;
                pend_d = 1'b0;
            end
        end
        if (!en || sync) begin
            clk_d = 1'b0;
        end else if (tc) begin
            // A mode change restarts both outputs low rather than emitting a partial cycle.
            clk_d  = (!chg && nmode == MODE_SQUARE) ? ~clk_q : 1'b0;
            tick_d = !chg && (nmode == MODE_TICK);
        end else begin
            cnt_d = cnt_q + DIV_W'(1);
        end
        if (wr) begin
            if (!en) begin
                // Idle channel: nothing to glitch, take the new config at once.
                div_d  = wdiv;
                mode_d = wmode;
                pend_d = 1'b0;
            end else begin
                // Running channel: last write wins, applied at the next restart.
                pdiv_d  = wdiv;
                pmode_d = wmode;
                pend_d  = 1'b1;
            end
        end
    end

    // State registers.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q   <= '0;
            div_q   <= DIV_W'(DEFAULT_DIV);
            mode_q  <= MODE_SQUARE;
            pdiv_q  <= DIV_W'(DEFAULT_DIV);
            pmode_q <= MODE_SQUARE;
            pend_q  <= 1'b0;
            clk_q   <= 1'b0;
            tick_q  <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            div_q   <= div_d;
            mode_q  <= mode_d;
            pdiv_q  <= pdiv_d;
            pmode_q <= pmode_d;
            pend_q  <= pend_d;
            clk_q   <= clk_d;
            tick_q  <= tick_d;
        end
    end

    assign clk_out = clk_q;
    assign tick    = tick_q;
    assign busy    = pend_q;

endmodule

// File: rtl/clk_div_bank.sv
// Bank of runtime-programmable clock dividers: config decode, error flag, channel array.
module clk_div_bank
    import clk_div_pkg::*;
#(
    parameter  int CHANNELS    = 4,
    parameter  int DIV_W       = 8,
    parameter  int DEFAULT_DIV = 50,
    localparam int CH_W        = ch_w(CHANNELS)
) (
    input  logic                clock,
    input  logic                rst_n,
    input  logic [CHANNELS-1:0] ch_en,
    input  logic                sync,
    input  logic                cfg_wr,
    input  logic [CH_W-1:0]     cfg_ch,
    input  logic [DIV_W-1:0]    cfg_div,
    input  logic                cfg_mode,
    output logic [CHANNELS-1:0] cfg_busy,
    output logic                cfg_err,
    output logic [CHANNELS-1:0] clk_out,
    output logic [CHANNELS-1:0] tick
);

    logic [CHANNELS-1:0] wr_sel;
    logic                cfg_err_q, cfg_err_d;

    // Decode the write target; a write that hits no channel is flagged and dropped.
    always_comb begin
        wr_sel = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            wr_sel[i] = cfg_wr && (int'(cfg_ch) == i);
        end
        cfg_err_d = cfg_wr && (wr_sel == '0);
    end

    // Error pulse register.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) cfg_err_q <= 1'b0;
        else        cfg_err_q <= cfg_err_d;
    end

    assign cfg_err = cfg_err_q;

    for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
        clk_div_channel #(
            .DIV_W       (DIV_W),
            .DEFAULT_DIV (DEFAULT_DIV)
        ) u_ch (
            .clock   (clock),
            .rst_n   (rst_n),
            .en      (ch_en[g]),
            .sync    (sync),
            .wr      (wr_sel[g]),
            .wdiv    (cfg_div),
            .wmode   (cfg_mode),
            .clk_out (clk_out[g]),
            .tick    (tick[g]),
            .busy    (cfg_busy[g])
        );
    end

endmodule

// File: tb/tb_clk_div_bank.sv
// Bench for clk_div_bank: output-edge scoreboard plus a table of single-channel vectors.
module tb_clk_div_bank;
    import clk_div_pkg::*;

    localparam int NCH = 3;

    logic           clock = 1'b0;
    logic           rst_n;
    logic [NCH-1:0] ch_en;
    logic           sync;
    logic           cfg_wr;
    logic [1:0]     cfg_ch;
    logic [7:0]     cfg_div;
    logic           cfg_mode;
    logic [NCH-1:0] cfg_busy;
    logic           cfg_err;
    logic [NCH-1:0] clk_out;
    logic [NCH-1:0] tick;

    clk_div_bank #(.CHANNELS(NCH), .DIV_W(8), .DEFAULT_DIV(50)) dut (
        .clock(clock), .rst_n(rst_n), .ch_en(ch_en), .sync(sync),
        .cfg_wr(cfg_wr), .cfg_ch(cfg_ch), .cfg_div(cfg_div), .cfg_mode(cfg_mode),
        .cfg_busy(cfg_busy), .cfg_err(cfg_err), .clk_out(clk_out), .tick(tick)
    );

    always #5 clock = ~clock;

    // kind: 0 clk_out, 1 tick, 2 cfg_busy, 3 cfg_err (ch 0)
    typedef struct { int ch; int kind; int val; int t; } ev_t;
    typedef struct { int ch; logic mode; int div; int win; int exp_rises; } vec_t;

    ev_t            exp_q[$];
    vec_t           vecs[6];
    int             cyc = 0, npass = 0, ntot = 0, rises = 0;
    bit             mon_on = 0;
    logic [NCH-1:0] p_clk = '0, p_tick = '0, p_busy = '0;
    logic           p_err = 1'b0;

    task automatic push(input int ch, input int kind, input int val, input int t);
        ev_t e;
        e.ch = ch; e.kind = kind; e.val = val; e.t = t;
        exp_q.push_back(e);
    endtask

    task automatic check(input string name, input int act, input int exp);
        ntot++;
        if (act == exp) npass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    // An observed output change must match one queued expectation exactly.
    task automatic observe(input int ch, input int kind, input int val);
        bit found = 0;
        for (int i = 0; i < exp_q.size(); i++) begin
            if (exp_q[i].ch == ch && exp_q[i].kind == kind &&
                exp_q[i].val == val && exp_q[i].t == cyc) begin
                exp_q.delete(i);
                found = 1;
                break;
            end
        end
        ntot++;
        if (found) begin
            npass++;
            if (kind < 2 && val == 1) rises++;
        end else begin
            $display("FAIL unexpected_edge ch%0d kind%0d: got %0d at cycle %0d expected no change",
                     ch, kind, val, cyc);
        end
    endtask

    task automatic check_left();
        foreach (exp_q[i]) begin
            ntot++;
            $display("FAIL missing_edge ch%0d kind%0d: got none expected %0d at cycle %0d",
                     exp_q[i].ch, exp_q[i].kind, exp_q[i].val, exp_q[i].t);
        end
        exp_q.delete();
    endtask

    // Advance one clock; sample outputs at the falling edge, drive 1 unit later.
    task automatic step();
        @(negedge clock);
        cyc++;
        if (mon_on) begin
            for (int c = 0; c < NCH; c++) begin
                if (clk_out[c] !== p_clk[c])  observe(c, 0, int'(clk_out[c]));
                if (tick[c]    !== p_tick[c]) observe(c, 1, int'(tick[c]));
                if (cfg_busy[c] !== p_busy[c]) observe(c, 2, int'(cfg_busy[c]));
            end
            if (cfg_err !== p_err) observe(0, 3, int'(cfg_err));
        end
        p_clk = clk_out; p_tick = tick; p_busy = cfg_busy; p_err = cfg_err;
        #1;
    endtask

    task automatic run_to(input int t);
        while (cyc < t) step();
    endtask

    task automatic wr(input int ch, input logic mode, input int div);
        cfg_wr = 1'b1; cfg_ch = 2'(ch); cfg_mode = mode; cfg_div = 8'(div);
        step();
        cfg_wr = 1'b0;
    endtask

    // Write sampled on rising edge t.
    task automatic wr_at(input int t, input int ch, input logic mode, input int div);
        run_to(t - 1);
        wr(ch, mode, div);
    endtask

    // Expected edges for a channel that starts counting from 0 on edge e with outputs low.
    task automatic gen(input int ch, input logic mode, input int d, input int e, input int last);
        int v;
        bit tc, tcp;
        v = 0;
        for (int t = e; t <= last; t++) begin
            tc  = (t - e >= d) && ((t - e - d) % (d + 1) == 0);
            tcp = (t - 1 - e >= d) && ((t - 1 - e - d) % (d + 1) == 0);
            if (mode == MODE_SQUARE) begin
                if (tc) begin v = 1 - v; push(ch, 0, v, t); end
            end else if (d == 0) begin
                if (t == e) push(ch, 1, 1, t);
            end else if (tc) begin
                push(ch, 1, 1, t);
            end else if (tcp) begin
                push(ch, 1, 0, t);
            end
        end
    endtask

    task automatic stop_all(input string name);
        mon_on = 0;
        ch_en = '0;
        step(); step();
        check({name, "_off_clk"}, int'(clk_out), 0);
        check({name, "_off_tick"}, int'(tick), 0);
        mon_on = 1;
    endtask

    initial begin
        int e, s;
        vecs[0] = '{ch: 0, mode: MODE_SQUARE, div: 0, win: 12, exp_rises: 6};
        vecs[1] = '{ch: 1, mode: MODE_TICK,   div: 3, win: 20, exp_rises: 5};
        vecs[2] = '{ch: 2, mode: MODE_SQUARE, div: 2, win: 20, exp_rises: 3};
        vecs[3] = '{ch: 0, mode: MODE_TICK,   div: 0, win: 8,  exp_rises: 1};
        vecs[4] = '{ch: 2, mode: MODE_TICK,   div: 1, win: 10, exp_rises: 5};
        vecs[5] = '{ch: 1, mode: MODE_SQUARE, div: 5, win: 30, exp_rises: 3};

        rst_n = 1'b0; ch_en = '1; sync = 1'b0;
        cfg_wr = 1'b0; cfg_ch = '0; cfg_div = '0; cfg_mode = 1'b0;
        step(); step(); step();
        check("rst_clk_out", int'(clk_out), 0);
        check("rst_tick", int'(tick), 0);
        check("rst_busy", int'(cfg_busy), 0);
        check("rst_err", int'(cfg_err), 0);

        // Defaults after reset: D=50 square on all channels, never busy.
        rst_n = 1'b1;
        e = cyc + 1;
        mon_on = 1;
        for (int c = 0; c < NCH; c++) gen(c, MODE_SQUARE, 50, e, e + 160);
        run_to(e + 160);
        check_left();
        stop_all("default");

        // Single-channel table: configure while idle, enable, count edges.
        foreach (vecs[i]) begin
            wr(vecs[i].ch, vecs[i].mode, vecs[i].div);
            e = cyc + 1;
            ch_en[vecs[i].ch] = 1'b1;
            rises = 0;
            gen(vecs[i].ch, vecs[i].mode, vecs[i].div, e, e + vecs[i].win - 1);
            run_to(e + vecs[i].win - 1);
            check_left();
            check($sformatf("vec%0d_rises", i), rises, vecs[i].exp_rises);
            check($sformatf("vec%0d_other_clk", i), int'(clk_out & ~(NCH'(1) << vecs[i].ch)), 0);
            stop_all($sformatf("vec%0d", i));
        end

        // Mid half-period rewrite: current half-period completes, then D=1.
        wr(0, MODE_SQUARE, 4);
        e = cyc + 1;
        ch_en = 3'b001;
        push(0, 0, 1, e + 4);  push(0, 2, 1, e + 6);
        push(0, 0, 0, e + 9);  push(0, 2, 0, e + 9);
        push(0, 0, 1, e + 11); push(0, 0, 0, e + 13); push(0, 0, 1, e + 15);
        wr_at(e + 6, 0, MODE_SQUARE, 1);
        run_to(e + 16);
        check_left();
        stop_all("rewrite");

        // Two writes before TC: only the last lands, busy clears once.
        wr(0, MODE_SQUARE, 4);
        e = cyc + 1;
        ch_en = 3'b001;
        push(0, 0, 1, e + 4);  push(0, 2, 1, e + 5);
        push(0, 0, 0, e + 9);  push(0, 2, 0, e + 9);
        push(0, 0, 1, e + 12); push(0, 0, 0, e + 15); push(0, 0, 1, e + 18);
        wr_at(e + 5, 0, MODE_SQUARE, 7);
        wr_at(e + 7, 0, MODE_SQUARE, 2);
        run_to(e + 19);
        check_left();
        stop_all("lastwins");

        // Sync restart of two channels, then a bad-channel write that changes nothing.
        wr(1, MODE_SQUARE, 2);
        wr(2, MODE_SQUARE, 5);
        e = cyc + 1;
        ch_en = 3'b110;
        s = e + 10;
        gen(1, MODE_SQUARE, 2, e, s - 1);
        gen(2, MODE_SQUARE, 5, e, s - 1);
        push(1, 0, 0, s); push(2, 0, 0, s);
        gen(1, MODE_SQUARE, 2, s + 1, s + 20);
        gen(2, MODE_SQUARE, 5, s + 1, s + 20);
        push(0, 3, 1, s + 13); push(0, 3, 0, s + 14);
        push(2, 2, 1, s + 19);
        run_to(s - 1);
        sync = 1'b1;
        step();
        sync = 1'b0;
        wr_at(s + 13, 3, MODE_SQUARE, 1);
        wr_at(s + 19, 2, MODE_TICK, 9);
        run_to(s + 20);
        check_left();
        check("pre_rst_clk", int'(clk_out), 3'b100);
        check("pre_rst_busy", int'(cfg_busy), 3'b100);

        // Asynchronous reset mid-count, then defaults again on every channel.
        mon_on = 0;
        rst_n = 1'b0;
        #1;
        check("async_rst_clk", int'(clk_out), 0);
        check("async_rst_busy", int'(cfg_busy), 0);
        check("async_rst_tick", int'(tick), 0);
        step(); step();
        ch_en = '1;
        rst_n = 1'b1;
        e = cyc + 1;
        mon_on = 1;
        for (int c = 0; c < NCH; c++) gen(c, MODE_SQUARE, 50, e, e + 55);
        run_to(e + 55);
        check_left();

        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end

endmodule
